// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared fetch-path constants and sequencer state encoding
package mips_defs;

    localparam int unsigned PC_W = 32;

    localparam logic [PC_W-1:0] PC_RESET   = 32'h0000_3000;
    localparam logic [PC_W-1:0] PC_EXC_VEC = 32'h0000_4180;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_pc_mux.sv
// rtl/pc_sequencer_pc_mux.sv - combinational priority select of the next fetch address
module pc_mux
    import mips_defs::*;
#(
    parameter logic [PC_W-1:0] EXC_VEC = PC_EXC_VEC
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_stall,
    input  logic            i_br_valid,
    input  logic [PC_W-1:0] i_br_target,
    input  logic            i_exc_req,
    input  logic            i_eret_req,
    input  logic [PC_W-1:0] i_epc,
    input  logic            i_pend,
    input  logic [PC_W-1:0] i_pend_addr,
    output logic [PC_W-1:0] o_next_pc
);

    // A latched redirect outranks a live br_valid: the stalled D instruction re-asserts it.
    always_comb begin
        o_next_pc = i_pc + 32'd4;
        if (i_exc_req) begin
            o_next_pc = EXC_VEC;
        end else if (i_eret_req) begin
            o_next_pc = i_epc;
        end else if (i_pend) begin
            o_next_pc = i_stall ? i_pc : i_pend_addr;
        end else if (i_br_valid) begin
            o_next_pc = i_stall ? i_pc : i_br_target;
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC register with stall handling and stalled-redirect latch
module pc_sequencer
    import mips_defs::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = PC_RESET,
    parameter logic [PC_W-1:0] EXC_VEC  = PC_EXC_VEC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [PC_W-1:0] epc,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            pc_adel,
    output logic            redir_pend
);

    seq_state_t      r_state;
    seq_state_t      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pend_addr;
    logic            r_squash;
    logic [PC_W-1:0] w_next_pc;
    logic            w_flush;
    logic            w_latch_redir;

    assign w_flush       = exc_req | eret_req;
    assign w_latch_redir = (r_state == RUN) & br_valid & stall & ~w_flush;

    pc_mux #(
        .EXC_VEC(EXC_VEC)
    ) u_pc_mux (
        .i_pc       (r_pc),
        .i_stall    (stall),
        .i_br_valid (br_valid),
        .i_br_target(br_target),
        .i_exc_req  (exc_req),
        .i_eret_req (eret_req),
        .i_epc      (epc),
        .i_pend     (r_state == PEND),
        .i_pend_addr(r_pend_addr),
        .o_next_pc  (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_flush) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                RUN:     w_state_next = w_latch_redir ? PEND : RUN;
                PEND:    w_state_next = stall ? PEND : RUN;
                default: w_state_next = RUN;
            endcase
        end
    end

    always_comb begin
        redir_pend = (r_state == PEND);
        pc_valid   = ~r_squash;
        pc_adel    = |r_pc[1:0];
        pc         = r_pc;
    end

    // An exception taken under stall leaves wrong-path IF content behind; squash one fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_pend_addr <= '0;
            r_squash    <= 1'b0;
        end else begin
            r_pc     <= w_next_pc;
            r_squash <= exc_req & stall;
            if (w_latch_redir) begin
                r_pend_addr <= br_target;
            end
        end
    end

endmodule
